// File: rtl/shader_pkg.sv
// Shared definitions for the shader sequencer: opcodes, FSM states and
// instruction field layout {op, mask, dest, srcA, srcB, imm}, MSB first.
package shader_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_MUL  = 3'b001,
        OP_AND  = 3'b010,
        OP_OR   = 3'b011,
        OP_NOP  = 3'b100,
        OP_LOOP = 3'b101,
        OP_RSV  = 3'b110,
        OP_HALT = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_e;

    localparam int OP_W  = 3;
    localparam int IMM_W = 8;

    function automatic int instr_width(input int lanes, input int rw);
        return OP_W + lanes + 3 * rw + IMM_W;
    endfunction

    function automatic int op_lsb(input int lanes, input int rw);
        return lanes + 3 * rw + IMM_W;
    endfunction

    function automatic int mask_lsb(input int rw);
        return 3 * rw + IMM_W;
    endfunction

    function automatic int dest_lsb(input int rw);
        return 2 * rw + IMM_W;
    endfunction

    function automatic int srca_lsb(input int rw);
        return rw + IMM_W;
    endfunction

    function automatic int srcb_lsb();
        return IMM_W;
    endfunction

endpackage

// File: rtl/shader_prog_mem.sv
// Program store for the shader sequencer: synchronous write, asynchronous read.
// Contents are deliberately not reset.
module shader_prog_mem #(
    parameter int DEPTH = 16,
    parameter int IW    = 24,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [IW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [IW-1:0] rdata
);

    logic [IW-1:0] mem_r [DEPTH];

    // Program write port
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];

endmodule

// File: rtl/shader_sequencer.sv
// Shader instruction sequencer: fetches, decodes and issues ALU instructions
// with a valid/ready handshake. Define SHADER_SEQ_LOOP_EN to enable LOOP.
module shader_sequencer
    import shader_pkg::*;
#(
    parameter int LANES  = 4,
    parameter int NREGS  = 8,
    parameter int DEPTH  = 16,
    localparam int RW    = $clog2(NREGS),
    localparam int AW    = $clog2(DEPTH),
    localparam int IW    = instr_width(LANES, RW)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [IW-1:0]    prog_wdata,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [1:0]       alu_op,
    output logic [LANES-1:0] lane_mask,
    output logic [RW-1:0]    dest,
    output logic [RW-1:0]    srcA,
    output logic [RW-1:0]    srcB,
    output logic [AW-1:0]    out_pc,
    output logic             busy,
    output logic             done
);

    localparam int OP_LSB   = op_lsb(LANES, RW);
    localparam int MASK_LSB = mask_lsb(RW);
    localparam int DEST_LSB = dest_lsb(RW);
    localparam int SRCA_LSB = srca_lsb(RW);
    localparam int SRCB_LSB = srcb_lsb();

    seq_state_e       state_r, state_nx_s;
    logic [AW-1:0]    pc_r, pc_inc_s;
    logic             launch_r;
    logic [IW-1:0]    instr_s;
    opcode_e          op_s;
    logic             start_ok_s, slot_free_s, fetch_en_s, mem_we_s;
    logic             busy_s, done_s;
    logic             unused_imm_s;

    logic             out_valid_r;
    logic [1:0]       alu_op_r;
    logic [LANES-1:0] lane_mask_r;
    logic [RW-1:0]    dest_r, srca_r, srcb_r;
    logic [AW-1:0]    out_pc_r;

`ifdef SHADER_SEQ_LOOP_EN
    logic             loop_act_r;
    logic [RW-1:0]    loop_cnt_r;
    logic [RW-1:0]    loop_req_s;
    logic [AW-1:0]    loop_tgt_s;

    assign loop_req_s = instr_s[DEST_LSB +: RW];
    assign loop_tgt_s = instr_s[AW-1:0];
`endif

    shader_prog_mem #(
        .DEPTH (DEPTH),
        .IW    (IW)
    ) u_prog_mem (
        .clk   (clk),
        .we    (mem_we_s),
        .waddr (prog_addr),
        .wdata (prog_wdata),
        .raddr (pc_r),
        .rdata (instr_s)
    );

    assign op_s         = opcode_e'(instr_s[OP_LSB +: OP_W]);
    assign unused_imm_s = ^instr_s[IMM_W-1:0];
    assign mem_we_s     = prog_we && (state_r != ST_RUN);
    assign start_ok_s   = start && (state_r != ST_RUN);
    assign pc_inc_s     = (pc_r == AW'(DEPTH - 1)) ? '0 : pc_r + AW'(1);
    // A HALT is only taken with a free slot, so a pending issue always drains first.
    assign slot_free_s  = !out_valid_r || out_ready;
    assign fetch_en_s   = (state_r == ST_RUN) && !launch_r && slot_free_s;

    // FSM state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nx_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nx_s = ST_RUN;
                else       state_nx_s = ST_IDLE;
            end
            ST_RUN: begin
                if (fetch_en_s && (op_s == OP_HALT)) state_nx_s = ST_DONE;
                else                                 state_nx_s = ST_RUN;
            end
            ST_DONE: begin
                if (start) state_nx_s = ST_RUN;
                else       state_nx_s = ST_DONE;
            end
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // FSM status outputs
    always_comb begin
        busy_s = 1'b0;
        done_s = 1'b0;
        case (state_r)
            ST_RUN:  busy_s = 1'b1;
            ST_DONE: done_s = 1'b1;
            default: begin
                busy_s = 1'b0;
                done_s = 1'b0;
            end
        endcase
    end

    // Fetch, pc/loop update and registered decode of issued instructions
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r        <= '0;
            launch_r    <= 1'b0;
            out_valid_r <= 1'b0;
            alu_op_r    <= 2'b00;
            lane_mask_r <= '0;
            dest_r      <= '0;
            srca_r      <= '0;
            srcb_r      <= '0;
            out_pc_r    <= '0;
`ifdef SHADER_SEQ_LOOP_EN
            loop_act_r  <= 1'b0;
            loop_cnt_r  <= '0;
`endif
        end else if (start_ok_s) begin
            // One priming cycle after start so the first issue lands two cycles later.
            pc_r        <= '0;
            launch_r    <= 1'b1;
`ifdef SHADER_SEQ_LOOP_EN
            loop_act_r  <= 1'b0;
            loop_cnt_r  <= '0;
`endif
        end else begin
            launch_r <= 1'b0;
            if (fetch_en_s) begin
                case (op_s)
                    OP_ADD, OP_MUL, OP_AND, OP_OR: begin
                        out_valid_r <= 1'b1;
                        alu_op_r    <= instr_s[OP_LSB +: 2];
                        lane_mask_r <= instr_s[MASK_LSB +: LANES];
                        dest_r      <= instr_s[DEST_LSB +: RW];
                        srca_r      <= instr_s[SRCA_LSB +: RW];
                        srcb_r      <= instr_s[SRCB_LSB +: RW];
                        out_pc_r    <= pc_r;
                        pc_r        <= pc_inc_s;
                    end
                    OP_HALT: begin
                        out_valid_r <= 1'b0;
                    end
`ifdef SHADER_SEQ_LOOP_EN
                    OP_LOOP: begin
                        out_valid_r <= 1'b0;
                        if (!loop_act_r) begin
                            if (loop_req_s == '0) begin
                                pc_r <= pc_inc_s;
                            end else begin
                                loop_act_r <= 1'b1;
                                loop_cnt_r <= loop_req_s - RW'(1);
                                pc_r       <= loop_tgt_s;
                            end
                        end else if (loop_cnt_r != '0) begin
                            loop_cnt_r <= loop_cnt_r - RW'(1);
                            pc_r       <= loop_tgt_s;
                        end else begin
                            loop_act_r <= 1'b0;
                            pc_r       <= pc_inc_s;
                        end
                    end
`endif
                    default: begin
                        out_valid_r <= 1'b0;
                        pc_r        <= pc_inc_s;
                    end
                endcase
            end else if (out_valid_r && out_ready) begin
                out_valid_r <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_r;
    assign alu_op    = alu_op_r;
    assign lane_mask = lane_mask_r;
    assign dest      = dest_r;
    assign srcA      = srca_r;
    assign srcB      = srcb_r;
    assign out_pc    = out_pc_r;
    assign busy      = busy_s;
    assign done      = done_s;

endmodule

// File: tb/tb_shader_sequencer.sv
// Scoreboard bench for shader_sequencer (default parameters); expected issues
// are queued as programs are loaded and compared against observed handshakes.
module tb_shader_sequencer;

    localparam int LANES = 4, NREGS = 8, DEPTH = 16, RW = 3, AW = 4, IW = 24;

    typedef struct packed {
        logic [1:0] op; logic [3:0] m; logic [2:0] d; logic [2:0] a; logic [2:0] b; logic [3:0] pc;
    } item_t;
    typedef struct packed { logic v; logic busy; logic done; item_t it; } snap_t;

    logic clk = 1'b0;
    logic rst, start, prog_we, out_ready;
    logic [AW-1:0] prog_addr;
    logic [IW-1:0] prog_wdata;
    logic out_valid, busy, done;
    logic [1:0] alu_op;
    logic [LANES-1:0] lane_mask;
    logic [RW-1:0] dest, srcA, srcB;
    logic [AW-1:0] out_pc;

    int n_cmp = 0, n_err = 0;
    item_t exp_q[$], got_q[$];
    int got_c[$];
    snap_t trace[$];

    shader_sequencer #(.LANES(LANES), .NREGS(NREGS), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .prog_we(prog_we), .prog_addr(prog_addr),
        .prog_wdata(prog_wdata), .out_valid(out_valid), .out_ready(out_ready), .alu_op(alu_op),
        .lane_mask(lane_mask), .dest(dest), .srcA(srcA), .srcB(srcB), .out_pc(out_pc),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] mk(input logic [2:0] op, input logic [3:0] m, input logic [2:0] d,
                                         input logic [2:0] a, input logic [2:0] b, input logic [7:0] imm);
        return {op, m, d, a, b, imm};
    endfunction

    function automatic item_t it(input logic [1:0] op, input logic [3:0] m, input logic [2:0] d,
                                 input logic [2:0] a, input logic [2:0] b, input logic [3:0] pc);
        return {op, m, d, a, b, pc};
    endfunction

    // All tasks are entered and left 1 time unit after a rising edge.
    task automatic load(input logic [3:0] addr, input logic [IW-1:0] data);
        prog_we = 1'b1; prog_addr = addr; prog_wdata = data;
        @(posedge clk); #1;
        prog_we = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Cycle c = period index after the edge that sampled start.
    task automatic run_collect(input int max_cyc, input int hold_from, input int hold_n,
                               input int we_at, input int rst_at, output int done_at);
        snap_t s;
        trace.delete(); got_q.delete(); got_c.delete();
        done_at = -1;
        for (int c = 0; c < max_cyc; c++) begin
            out_ready  = !(c >= hold_from && c < hold_from + hold_n);
            prog_we    = (c == we_at);
            prog_addr  = 4'd0;
            prog_wdata = mk(3'b011, 4'hf, 3'd7, 3'd7, 3'd7, 8'd0);
            rst        = (c == rst_at);
            @(negedge clk);
            s.v = out_valid; s.busy = busy; s.done = done;
            s.it = {alu_op, lane_mask, dest, srcA, srcB, out_pc};
            trace.push_back(s);
            if (out_valid && out_ready && !rst) begin
                got_q.push_back(s.it);
                got_c.push_back(c);
            end
            if (done && done_at < 0) done_at = c;
            @(posedge clk); #1;
            if (done_at >= 0 || (rst_at >= 0 && c == rst_at + 1)) break;
        end
        out_ready = 1'b1; prog_we = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; prog_we = 1'b0; out_ready = 1'b1;
        prog_addr = '0; prog_wdata = '0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_cmp++;
        if ({alu_op, lane_mask, dest, srcA, srcB, out_pc} !== 19'd0) begin
            n_err++; $display("FAIL reset_fields: got %h expected 0", {alu_op, lane_mask, dest, srcA, srcB, out_pc});
        end
        n_cmp++;
        if ({busy, done} !== 2'b00) begin n_err++; $display("FAIL reset_status: got %b expected 00", {busy, done}); end
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        item_t e, g;
        int done_at;
        load(4'd1, mk(3'b001, 4'b0101, 3'd3, 3'd4, 3'd5, 8'd0));
        load(4'd2, mk(3'b111, 4'b0000, 3'd0, 3'd0, 3'd0, 8'd0));
        exp_q.push_back(it(2'b00, 4'b1111, 3'd0, 3'd1, 3'd2, 4'd0));
        exp_q.push_back(it(2'b01, 4'b0101, 3'd3, 3'd4, 3'd5, 4'd1));
        // ADD written on the same edge that samples start
        prog_we = 1'b1; prog_addr = 4'd0; prog_wdata = mk(3'b000, 4'b1111, 3'd0, 3'd1, 3'd2, 8'd0);
        pulse_start();
        prog_we = 1'b0;
        run_collect(20, -1, 0, -1, -1, done_at);
        n_cmp++;
        if (got_c.size() < 2 || got_c[0] != 2 || got_c[1] != 3) begin
            n_err++; $display("FAIL basic_timing: got %0d issues first at c%0d, expected issues at c2,c3",
                              got_c.size(), (got_c.size() != 0) ? got_c[0] : -1);
        end
        n_cmp++;
        if (done_at != 4) begin n_err++; $display("FAIL basic_done: got cycle %0d expected 4", done_at); end
        n_cmp++;
        if (trace[0].busy !== 1'b1 || trace[1].v !== 1'b0) begin
            n_err++; $display("FAIL basic_busy_rise: got busy=%b v1=%b expected 1 0", trace[0].busy, trace[1].v);
        end
        n_cmp++;
        if (trace.size() < 5 || trace[4].busy !== 1'b0) begin
            n_err++; $display("FAIL basic_busy_fall: busy still high at done");
        end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = (got_q.size() != 0) ? got_q.pop_front() : item_t'('x);
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL basic_issue: got %h expected %h", g, e); end
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_err++; $display("FAIL basic_extra: got %0d extra expected 0", got_q.size()); end
    endtask

    task automatic test_stall();
        item_t e, g;
        int done_at;
        snap_t hold_exp;
        hold_exp = {1'b1, 1'b1, 1'b0, it(2'b00, 4'b1111, 3'd0, 3'd1, 3'd2, 4'd0)};
        exp_q.push_back(it(2'b00, 4'b1111, 3'd0, 3'd1, 3'd2, 4'd0));
        exp_q.push_back(it(2'b01, 4'b0101, 3'd3, 3'd4, 3'd5, 4'd1));
        pulse_start();
        run_collect(20, 2, 3, -1, -1, done_at);
        for (int c = 2; c < 5; c++) begin
            n_cmp++;
            if (trace.size() <= c || trace[c] !== hold_exp) begin
                n_err++; $display("FAIL stall_hold_c%0d: got %h expected %h", c, (trace.size() > c) ? trace[c] : snap_t'('x), hold_exp);
            end
        end
        n_cmp++;
        if (done_at != 7) begin n_err++; $display("FAIL stall_done: got cycle %0d expected 7", done_at); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = (got_q.size() != 0) ? got_q.pop_front() : item_t'('x);
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL stall_issue: got %h expected %h", g, e); end
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_err++; $display("FAIL stall_extra: got %0d extra expected 0", got_q.size()); end
    endtask

    task automatic load_loop_prog();
        load(4'd0, mk(3'b000, 4'b0011, 3'd1, 3'd2, 3'd3, 8'd0));
        load(4'd1, mk(3'b101, 4'b0000, 3'd2, 3'd0, 3'd0, 8'd0));
        load(4'd2, mk(3'b111, 4'b0000, 3'd0, 3'd0, 3'd0, 8'd0));
    endtask

    task automatic test_loop();
        item_t e, g;
        int done_at, n_iter, exp_done;
`ifdef SHADER_SEQ_LOOP_EN
        n_iter = 3; exp_done = 8;
`else
        n_iter = 1; exp_done = 4;
`endif
        load_loop_prog();
        for (int k = 0; k < n_iter; k++) exp_q.push_back(it(2'b00, 4'b0011, 3'd1, 3'd2, 3'd3, 4'd0));
        pulse_start();
        run_collect(40, -1, 0, -1, -1, done_at);
        n_cmp++;
        if (done_at != exp_done) begin n_err++; $display("FAIL loop_done: got cycle %0d expected %0d", done_at, exp_done); end
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = (got_q.size() != 0) ? got_q.pop_front() : item_t'('x);
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL loop_issue: got %h expected %h", g, e); end
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_err++; $display("FAIL loop_extra: got %0d extra expected 0", got_q.size()); end
    endtask

    task automatic test_we_in_run();
        item_t e, g;
        int done_at;
        load(4'd0, mk(3'b000, 4'b1111, 3'd0, 3'd1, 3'd2, 8'd0));
        load(4'd1, mk(3'b001, 4'b0101, 3'd3, 3'd4, 3'd5, 8'd0));
        load(4'd2, mk(3'b111, 4'b0000, 3'd0, 3'd0, 3'd0, 8'd0));
        for (int run = 0; run < 2; run++) begin
            exp_q.push_back(it(2'b00, 4'b1111, 3'd0, 3'd1, 3'd2, 4'd0));
            exp_q.push_back(it(2'b01, 4'b0101, 3'd3, 3'd4, 3'd5, 4'd1));
            pulse_start();
            run_collect(20, -1, 0, (run == 0) ? 1 : -1, -1, done_at);
            while (exp_q.size() != 0) begin
                e = exp_q.pop_front(); g = (got_q.size() != 0) ? got_q.pop_front() : item_t'('x);
                n_cmp++; if (g !== e) begin n_err++; $display("FAIL we_run%0d_issue: got %h expected %h", run, g, e); end
            end
        end
    endtask

    task automatic test_reset_mid_loop();
        item_t e, g;
        int done_at, rst_at, n_iter, exp_done;
`ifdef SHADER_SEQ_LOOP_EN
        rst_at = 4; n_iter = 3; exp_done = 8;
        exp_q.push_back(it(2'b00, 4'b0011, 3'd1, 3'd2, 3'd3, 4'd0));
`else
        rst_at = 2; n_iter = 1; exp_done = 4;
`endif
        load_loop_prog();
        pulse_start();
        run_collect(20, -1, 0, -1, rst_at, done_at);
        n_cmp++;
        if (trace.size() <= rst_at || trace[rst_at].v !== 1'b1) begin
            n_err++; $display("FAIL rstloop_pending: no valid issue when reset was applied");
        end
        n_cmp++;
        if (trace.size() <= rst_at + 1 || trace[rst_at + 1] !== snap_t'(0)) begin
            n_err++; $display("FAIL rstloop_clear: got %h expected 0", (trace.size() > rst_at + 1) ? trace[rst_at + 1] : snap_t'('x));
        end
        for (int k = 0; k < n_iter; k++) exp_q.push_back(it(2'b00, 4'b0011, 3'd1, 3'd2, 3'd3, 4'd0));
        while (exp_q.size() != 0) begin
            // first pass drains the pre-reset issue, then the fresh rerun is collected
            if (got_q.size() == 0 && trace.size() != 0 && trace[0].busy === 1'b1 && done_at < 0) begin
                pulse_start();
                run_collect(40, -1, 0, -1, -1, done_at);
                n_cmp++;
                if (done_at != exp_done) begin n_err++; $display("FAIL rstloop_done: got cycle %0d expected %0d", done_at, exp_done); end
            end
            e = exp_q.pop_front(); g = (got_q.size() != 0) ? got_q.pop_front() : item_t'('x);
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL rstloop_issue: got %h expected %h", g, e); end
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_err++; $display("FAIL rstloop_extra: got %0d extra expected 0", got_q.size()); end
    endtask

    task automatic test_wrap();
        item_t e, g;
        int done_at;
        logic [3:0] iv;
        for (int i = 0; i < DEPTH; i++) begin
            iv = 4'(i);
            load(iv, mk({1'b0, iv[1:0]}, iv, 3'(i % 8), 3'((i + 1) % 8), 3'((i + 2) % 8), 8'd0));
        end
        for (int k = 0; k < 20; k++) begin
            iv = 4'(k % DEPTH);
            exp_q.push_back(it(iv[1:0], iv, 3'(k % 8), 3'((k + 1) % 8), 3'((k + 2) % 8), iv));
        end
        pulse_start();
        run_collect(30, -1, 0, -1, 22, done_at);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front(); g = (got_q.size() != 0) ? got_q.pop_front() : item_t'('x);
            n_cmp++; if (g !== e) begin n_err++; $display("FAIL wrap_issue: got %h expected %h", g, e); end
        end
        n_cmp++;
        if (got_q.size() != 0) begin n_err++; $display("FAIL wrap_extra: got %0d extra expected 0", got_q.size()); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stall();
        test_loop();
        test_we_in_run();
        test_reset_mid_loop();
        test_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/shader_sequencer.md
SHADER_SEQUENCER -- requirements
Module: shader_sequencer

Interface
REQ-001 SHALL have parameter LANES, default 4, meaning SIMD lane count and lane-mask width.
REQ-002 SHALL have parameter NREGS, default 8, meaning register count; RW = clog2(NREGS).
REQ-003 SHALL have parameter DEPTH, default 16, meaning program memory depth; AW = clog2(DEPTH), AW <= 8.
REQ-004 SHALL use instruction width IW = 3+LANES+3*RW+8; fields MSB-first: op[3], mask[LANES], dest[RW], srcA[RW], srcB[RW], imm[8].
REQ-005 SHALL have ports:
  clk  in  1  clock
  rst  in  1  synchronous active-high reset
  start  in  1  begin execution at address 0
  prog_we  in  1  program write strobe
  prog_addr  in  AW  write address
  prog_wdata  in  IW  write data
  out_valid  out  1  decoded ALU instruction available
  out_ready  in  1  execution unit accepts
  alu_op  out  2  00 ADD, 01 MUL, 10 AND, 11 OR
  lane_mask  out  LANES  per-lane enable
  dest, srcA, srcB  out  RW each  register indices
  out_pc  out  AW  address of issued instruction
  busy  out  1  state is RUN
  done  out  1  HALT reached; held until next start or rst

Function
REQ-006 SHALL use opcodes 000-011 as ALU ops, 100 NOP, 101 LOOP, 111 HALT; 110 behaves as NOP.
REQ-007 SHALL implement FSM IDLE -> RUN on start; RUN -> DONE on HALT fetch; DONE -> RUN on start; start ignored in RUN.
REQ-008 SHALL set pc=0 and clear loop state on accepted start; first out_valid SHALL rise 2 cycles after start sampled.
REQ-009 SHALL fetch mem[pc] asynchronously and register decoded fields into outputs; one fetch per cycle when output slot free.
REQ-010 SHALL hold all outputs stable while out_valid=1 and out_ready=0; pc SHALL not advance.
REQ-011 SHALL sustain one issued instruction per cycle while out_ready=1.
REQ-012 SHALL consume one cycle for NOP, LOOP, HALT without asserting out_valid.
REQ-013 LOOP: target = imm[AW-1:0], count = dest field; if loop inactive and count=0 -> pc+1; inactive and count>0 -> active, cnt=count-1, pc=target; active and cnt>0 -> cnt-1, pc=target; active and cnt=0 -> inactive, pc+1 (body runs count+1 times; no nesting).
REQ-014 SHALL wrap pc from DEPTH-1 to 0 modulo DEPTH.
REQ-015 SHALL accept prog_we only in IDLE or DONE; ignore it in RUN.
REQ-016 Write and start on same edge SHALL both take effect; first fetch sees the written data.
REQ-017 SHALL let a pending out_valid instruction complete its handshake after HALT fetch before done asserts.

Reset
REQ-018 rst SHALL force IDLE, pc=0, loop inactive, out_valid=0, alu_op/lane_mask/dest/srcA/srcB/out_pc=0, busy=0, done=0.
REQ-019 rst mid-RUN SHALL abort immediately; program memory contents SHALL NOT be reset.

Configuration
REQ-020 SHALL support macro SHADER_SEQ_LOOP_EN: defined -> LOOP per REQ-013; undefined -> LOOP behaves as NOP and no loop counter/flag is synthesised.

Structure
REQ-021 SHALL place opcode enum, field-width functions and instruction field offsets in package shader_pkg.
REQ-022 SHALL instantiate sub-module shader_prog_mem (DEPTH x IW, sync write, async read).

Verification
REQ-023 Load {ADD m=1111 d0 a1 b2, MUL m=0101, HALT}, start, ready=1 -> ADD at cycle+2, MUL at +3, done at +4, busy falls.
REQ-024 Same program, out_ready low 3 cycles during ADD -> ADD fields and out_pc=0 stable 3 cycles, MUL follows with no loss or duplicate.
REQ-025 LOOP_EN: {ADD, LOOP tgt=0 cnt=2, HALT} -> ADD issued exactly 3 times then done; without macro ADD issued once.
REQ-026 prog_we to addr 0 during RUN -> memory unchanged, next run issues original instruction.
REQ-027 rst asserted mid-loop with out_valid=1 -> next cycle all outputs 0, IDLE; restart reruns program from pc 0 with loop count fresh.
REQ-028 Program with no HALT, DEPTH=16 -> pc wraps 15 -> 0, out_pc sequence continuous.
